// File: rtl/ahb_mem_slave_if.sv
// rtl/ahb_mem_slave_if.sv - AHB bus signals between a master and the byte-memory slave
// Clock and reset are plain ports on the modules; only bus signals live here.
interface ahb_mem_slave_if;
  logic        hsel;
  logic [20:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [7:0]  hwdata;
  logic [7:0]  hrdata;
  logic        hready;
  logic        hresp;

  modport master (
    output hsel, haddr, hwrite, htrans, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, hwrite, htrans, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB slave over a byte-wide memory with two-cycle ERROR for out-of-range addresses
// Define AHB_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states on every in-range transfer.
module ahb_mem_slave #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           hclk,
  input  logic           hreset,
  ahb_mem_slave_if.slave bus
);
  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
`ifdef AHB_SLAVE_WAIT_EN
    , ST_WAIT = 2'd3
`endif
  } state_t;

  logic [7:0]    mem [0:MEM_DEPTH-1];
  state_t        state;
  state_t        state_nxt;
  logic          hready_q;
  logic          accept;
  logic          in_range;
  logic          commit;
  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] addr_idx;
  logic [7:0]    rdata_q;
  logic          unused_htrans0;

  // hready doubles as the global ready this slave samples, so it is a pure function of state
  assign hready_q   = (state == ST_IDLE) || (state == ST_ERR2);
  assign bus.hready = hready_q;
  assign bus.hresp  = (state == ST_ERR1) || (state == ST_ERR2);
  assign bus.hrdata = rdata_q;

  assign accept         = bus.hsel && bus.htrans[1] && hready_q;
  assign in_range       = ({1'b0, bus.haddr} < 22'(MEM_DEPTH));
  assign addr_idx       = bus.haddr[AW-1:0];
  assign commit         = wr_pend && hready_q;
  assign unused_htrans0 = bus.htrans[0];

`ifdef AHB_SLAVE_WAIT_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wait_cnt <= '0;
    end else if (accept && in_range) begin
      wait_cnt <= 4'(WAIT_CYCLES);
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept && !in_range) begin
          state_nxt = ST_ERR1;
        end else if (accept) begin
`ifdef AHB_SLAVE_WAIT_EN
          state_nxt = ST_WAIT;
`else
          state_nxt = ST_IDLE;
`endif
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
`ifdef AHB_SLAVE_WAIT_EN
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_nxt = ST_IDLE;
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/control pipeline: only advances on edges where the previous data phase ends
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      rdata_q <= 8'h00;
    end else if (hready_q) begin
      wr_pend <= accept && in_range && bus.hwrite;
      if (accept) begin
        wr_addr <= addr_idx;
      end
      if (accept && in_range && !bus.hwrite) begin
        // A write committing on this same edge has not reached mem yet
        if (wr_pend && (wr_addr == addr_idx)) begin
          rdata_q <= bus.hwdata;
        end else begin
          rdata_q <= mem[addr_idx];
        end
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (commit) begin
      mem[wr_addr] <= bus.hwdata;
    end
  end
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - directed self-checking bench for ahb_mem_slave
module tb_ahb_mem_slave;
`ifdef AHB_SLAVE_WAIT_EN
  localparam int EXP_WAIT = 3;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic hclk;
  logic hreset;
  int   total = 0;
  int   bad   = 0;
  int   n;

  ahb_mem_slave_if bus ();

  ahb_mem_slave #(.MEM_DEPTH(256), .WAIT_CYCLES(3)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic [20:0] a, input logic w, input logic [1:0] t);
    bus.hsel   = 1'b1;
    bus.haddr  = a;
    bus.hwrite = w;
    bus.htrans = t;
  endtask

  task automatic idle();
    bus.hsel   = 1'b0;
    bus.hwrite = 1'b0;
    bus.htrans = T_IDLE;
  endtask

  task automatic wait_ready(input bit scramble, output int cnt);
    cnt = 0;
    while (bus.hready !== 1'b1 && cnt < 20) begin
      if (scramble) bus.haddr = 21'h1AB + 21'(cnt);
      @(negedge hclk);
      cnt++;
    end
  endtask

  task automatic write1(input logic [20:0] a, input logic [7:0] d, input string tag);
    int w;
    addr_phase(a, 1'b1, T_NONSEQ);
    @(negedge hclk);
    idle();
    bus.hwdata = d;
    wait_ready(1'b1, w);
    chk({tag, " waits"}, w, EXP_WAIT);
    @(negedge hclk);
  endtask

  task automatic read1(input logic [20:0] a, input logic [7:0] exp, input string tag);
    int w;
    addr_phase(a, 1'b0, T_NONSEQ);
    @(negedge hclk);
    idle();
    chk({tag, " data"}, bus.hrdata, exp);
    chk({tag, " resp"}, bus.hresp, 1'b0);
    wait_ready(1'b1, w);
    chk({tag, " waits"}, w, EXP_WAIT);
    chk({tag, " held"}, bus.hrdata, exp);
    @(negedge hclk);
  endtask

  initial begin
    hreset     = 1'b1;
    bus.hwdata = 8'h00;
    bus.haddr  = '0;
    idle();
    @(negedge hclk);
    chk("rst hrdata", bus.hrdata, 8'h00);
    chk("rst hready", bus.hready, 1'b1);
    chk("rst hresp", bus.hresp, 1'b0);
    hreset = 1'b0;

    write1(21'h010, 8'hA5, "wr10");
    read1(21'h010, 8'hA5, "rd10");

    // write 0x20 then read 0x20 pipelined on the commit edge
    write1(21'h020, 8'h11, "wr20a");
    addr_phase(21'h020, 1'b1, T_NONSEQ);
    @(negedge hclk);
    bus.hwdata = 8'h3C;
    addr_phase(21'h020, 1'b0, T_NONSEQ);
    wait_ready(1'b0, n);
    chk("byp wr waits", n, EXP_WAIT);
    @(negedge hclk);
    idle();
    chk("byp data", bus.hrdata, 8'h3C);
    wait_ready(1'b1, n);
    chk("byp rd waits", n, EXP_WAIT);
    @(negedge hclk);
    read1(21'h020, 8'h3C, "rd20");

    // out-of-range read, then a read accepted on the ERR2 edge
    write1(21'h000, 8'h5A, "wr00");
    addr_phase(21'h000100, 1'b0, T_NONSEQ);
    @(negedge hclk);
    idle();
    chk("err1 hready", bus.hready, 1'b0);
    chk("err1 hresp", bus.hresp, 1'b1);
    chk("err1 hrdata", bus.hrdata, 8'h3C);
    @(negedge hclk);
    chk("err2 hready", bus.hready, 1'b1);
    chk("err2 hresp", bus.hresp, 1'b1);
    addr_phase(21'h010, 1'b0, T_NONSEQ);
    @(negedge hclk);
    idle();
    chk("post-err data", bus.hrdata, 8'hA5);
    chk("post-err hresp", bus.hresp, 1'b0);
    wait_ready(1'b1, n);
    chk("post-err waits", n, EXP_WAIT);
    @(negedge hclk);

    // out-of-range write must not alias onto location 0
    addr_phase(21'h000100, 1'b1, T_NONSEQ);
    @(negedge hclk);
    idle();
    bus.hwdata = 8'hEE;
    chk("werr1 hresp", bus.hresp, 1'b1);
    @(negedge hclk);
    chk("werr2 hready", bus.hready, 1'b1);
    @(negedge hclk);
    chk("werr done hresp", bus.hresp, 1'b0);
    read1(21'h000, 8'h5A, "rd00");

    // BUSY and unselected transfers do nothing
    write1(21'h005, 8'h77, "wr05");
    addr_phase(21'h005, 1'b1, T_BUSY);
    @(negedge hclk);
    bus.hwdata = 8'hFF;
    chk("busy hready", bus.hready, 1'b1);
    chk("busy hresp", bus.hresp, 1'b0);
    addr_phase(21'h005, 1'b1, T_NONSEQ);
    bus.hsel = 1'b0;
    @(negedge hclk);
    bus.hwdata = 8'hFF;
    chk("unsel hready", bus.hready, 1'b1);
    chk("unsel hresp", bus.hresp, 1'b0);
    idle();
    @(negedge hclk);
    read1(21'h005, 8'h77, "rd05");

`ifndef AHB_SLAVE_WAIT_EN
    // sustained one-per-cycle writes then reads
    for (int i = 0; i < 5; i++) begin
      if (i < 4) addr_phase(21'h030 + 21'(i), 1'b1, (i == 0) ? T_NONSEQ : T_SEQ);
      else idle();
      if (i > 0) bus.hwdata = 8'h40 + 8'(i - 1);
      @(negedge hclk);
      chk("b2b wr hready", bus.hready, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      addr_phase(21'h030 + 21'(i), 1'b0, (i == 0) ? T_NONSEQ : T_SEQ);
      @(negedge hclk);
      chk("b2b rd data", bus.hrdata, 8'h40 + 8'(i));
      chk("b2b rd hready", bus.hready, 1'b1);
    end
    idle();
    @(negedge hclk);
`endif

    // reset while a write to 0x10 is in its data phase
    addr_phase(21'h010, 1'b1, T_NONSEQ);
    @(negedge hclk);
    idle();
    bus.hwdata = 8'h99;
    #2;
    hreset = 1'b1;
    #1;
    chk("mid-rst hrdata", bus.hrdata, 8'h00);
    chk("mid-rst hready", bus.hready, 1'b1);
    chk("mid-rst hresp", bus.hresp, 1'b0);
    @(negedge hclk);
    hreset = 1'b0;
    read1(21'h010, 8'hA5, "rd10 after rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
